prco_exec: RTL and testbench

//  Execute stage of the prco pipeline. Sits directly downstream of the register-read stage.

---
 rtl/prco_exec_pkg.sv | 30 +++
 rtl/prco_exec_mul_iter.sv | 48 ++++
 rtl/prco_exec.sv | 176 +++++++++++++++++
 tb/tb_prco_exec.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_exec_pkg.sv
// Shared prco execute-stage definitions: opcodes, flag bit indices, FSM states.
// Latency: n/a. Backpressure: n/a.
package prco_exec_pkg;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_MOVI = 6'h01;
  localparam logic [5:0] OP_MOV  = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h03;
  localparam logic [5:0] OP_SUB  = 6'h04;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_XOR  = 6'h07;
  localparam logic [5:0] OP_SHL  = 6'h08;
  localparam logic [5:0] OP_SHR  = 6'h09;
  localparam logic [5:0] OP_MUL  = 6'h0A;
  localparam logic [5:0] OP_CMP  = 6'h0B;
  localparam logic [5:0] OP_JMP  = 6'h0C;
  localparam logic [5:0] OP_JE   = 6'h0D;
  localparam logic [5:0] OP_JNE  = 6'h0E;
  localparam logic [5:0] OP_JL   = 6'h0F;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  function automatic logic is_multi(input logic [5:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
  endfunction
endpackage

// File: rtl/prco_exec_mul_iter.sv
// Shift-add multiplier, one partial product per cycle, low DATA_W bits kept.
// Latency: DATA_W cycles after i_start. Backpressure: none; i_abort drops the op in flight.
module prco_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_abort,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              q_done,
  output logic [DATA_W-1:0] q_prod
);
  localparam int CNT_W = $clog2(DATA_W);

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] a_r, b_r, acc;

  // q_prod already includes this cycle's partial product, so done is usable combinationally
  assign q_prod = acc + (b_r[0] ? a_r : '0);
  assign q_done = busy && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
    end else if (i_abort) begin
      busy <= 1'b0;
    end else if (i_start) begin
      busy <= 1'b1;
      cnt  <= '0;
      a_r  <= i_a;
      b_r  <= i_b;
      acc  <= '0;
    end else if (busy) begin
      acc  <= q_prod;
      a_r  <= {a_r[DATA_W-2:0], 1'b0};
      b_r  <= {1'b0, b_r[DATA_W-1:1]};
      cnt  <= cnt + 1'b1;
      if (q_done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/prco_exec.sv
// prco execute stage: ALU, iterative SHL/SHR/MUL, Z/N/C flags, jump resolution.
// Latency 1 (single-cycle ops), max(cnt,1)+1 for shifts, 17 for MUL; holds all outputs while downstream stalls.
module prco_exec
  import prco_exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6,
  parameter int SEL_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_p_cp,
  input  logic              i_p_valid,
  output logic              q_p_stalled,
  input  logic              i_p_stalled,
  output logic              q_p_valid,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_opa,
  input  logic [DATA_W-1:0] i_opb,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [SEL_W-1:0]  i_seld,
  output logic              q_wb_we,
  output logic [SEL_W-1:0]  q_wb_sel,
  output logic [DATA_W-1:0] q_wb_data,
  output logic [2:0]        q_flags,
  output logic              q_jmp_en,
  output logic [DATA_W-1:0] q_jmp_addr,
  output logic              q_illegal
);
  state_t            state;
  logic [5:0]        op6, op_r;
  logic [SEL_W-1:0]  sel_r;
  logic [DATA_W-1:0] acc, step;
  logic [3:0]        cnt_r;
  logic              hold, accept, mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [DATA_W:0]   sum, diff;

  logic [DATA_W-1:0] s_data, s_addr, b_data;
  logic              s_we, s_jmp, s_ill, b_done;
  logic [2:0]        s_flags;

  assign op6         = 6'(i_op);
  assign hold        = q_p_valid && i_p_stalled;
  assign q_p_stalled = (state == ST_BUSY) || hold;
  assign accept      = i_p_valid && !q_p_stalled && !i_p_cp;
  assign sum         = {1'b0, i_opa} + {1'b0, i_opb};
  assign diff        = {1'b0, i_opa} - {1'b0, i_opb};
  assign step        = (op_r == OP_SHL) ? {acc[DATA_W-2:0], 1'b0} : {1'b0, acc[DATA_W-1:1]};

  prco_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_abort (i_p_cp),
    .i_start (accept && (op6 == OP_MUL)),
    .i_a     (i_opa),
    .i_b     (i_opb),
    .q_done  (mul_done),
    .q_prod  (mul_prod)
  );

  // Branches read q_flags, i.e. the flags left by the previous flag-setting op
  always_comb begin
    s_data  = '0;
    s_we    = 1'b0;
    s_jmp   = 1'b0;
    s_ill   = 1'b0;
    s_addr  = '0;
    s_flags = q_flags;
    case (op6)
      OP_NOP, OP_SHL, OP_SHR, OP_MUL: ;
      OP_MOVI: begin s_data = i_imm;         s_we = 1'b1; end
      OP_MOV:  begin s_data = i_opb;         s_we = 1'b1; end
      OP_AND:  begin s_data = i_opa & i_opb; s_we = 1'b1; end
      OP_OR:   begin s_data = i_opa | i_opb; s_we = 1'b1; end
      OP_XOR:  begin s_data = i_opa ^ i_opb; s_we = 1'b1; end
      OP_ADD: begin
        s_data          = sum[DATA_W-1:0];
        s_we            = 1'b1;
        s_flags[FLAG_C] = sum[DATA_W];
        s_flags[FLAG_N] = sum[DATA_W-1];
        s_flags[FLAG_Z] = ~|sum[DATA_W-1:0];
      end
      OP_SUB, OP_CMP: begin
        s_data          = diff[DATA_W-1:0];
        s_we            = (op6 == OP_SUB);
        s_flags[FLAG_C] = diff[DATA_W];
        s_flags[FLAG_N] = diff[DATA_W-1];
        s_flags[FLAG_Z] = ~|diff[DATA_W-1:0];
      end
      OP_JMP:  begin s_jmp = 1'b1;              s_addr = i_imm; end
      OP_JE:   begin s_jmp = q_flags[FLAG_Z];   s_addr = i_imm; end
      OP_JNE:  begin s_jmp = !q_flags[FLAG_Z];  s_addr = i_imm; end
      OP_JL:   begin s_jmp = q_flags[FLAG_N];   s_addr = i_imm; end
      default: s_ill = 1'b1;
    endcase
  end

  // A shift count of 0 still costs one busy cycle and passes opa through
  always_comb begin
    b_done = 1'b0;
    b_data = acc;
    if (op_r == OP_MUL) begin
      b_done = mul_done;
      b_data = mul_prod;
    end else begin
      b_done = (cnt_r <= 4'd1);
      b_data = (cnt_r == 4'd0) ? acc : step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      op_r       <= '0;
      sel_r      <= '0;
      acc        <= '0;
      cnt_r      <= '0;
      q_p_valid  <= 1'b0;
      q_wb_we    <= 1'b0;
      q_wb_sel   <= '0;
      q_wb_data  <= '0;
      q_flags    <= '0;
      q_jmp_en   <= 1'b0;
      q_jmp_addr <= '0;
      q_illegal  <= 1'b0;
    end else if (i_p_cp) begin
      state     <= ST_IDLE;
      q_p_valid <= 1'b0;
      q_wb_we   <= 1'b0;
      q_jmp_en  <= 1'b0;
      q_illegal <= 1'b0;
    end else if (!hold) begin
      q_p_valid <= 1'b0;
      q_wb_we   <= 1'b0;
      q_jmp_en  <= 1'b0;
      q_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_multi(op6)) begin
              state <= ST_BUSY;
              op_r  <= op6;
              sel_r <= i_seld;
              acc   <= i_opa;
              cnt_r <= i_opb[3:0];
            end else begin
              q_p_valid  <= 1'b1;
              q_wb_we    <= s_we;
              q_wb_sel   <= i_seld;
              q_wb_data  <= s_data;
              q_flags    <= s_flags;
              q_jmp_en   <= s_jmp;
              q_jmp_addr <= s_addr;
              q_illegal  <= s_ill;
            end
          end
        end
        ST_BUSY: begin
          if (b_done) begin
            state      <= ST_IDLE;
            q_p_valid  <= 1'b1;
            q_wb_we    <= 1'b1;
            q_wb_sel   <= sel_r;
            q_wb_data  <= b_data;
            q_jmp_addr <= '0;
          end else if (op_r != OP_MUL) begin
            acc   <= step;
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prco_exec.sv
// Self-checking bench for prco_exec against an arithmetic reference model.
module tb_prco_exec;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_p_cp = 1'b0;
  logic        i_p_valid = 1'b0;
  logic        i_p_stalled = 1'b0;
  logic [5:0]  i_op = '0;
  logic [15:0] i_opa = '0, i_opb = '0, i_imm = '0;
  logic [2:0]  i_seld = '0;
  logic        q_p_stalled, q_p_valid, q_wb_we, q_jmp_en, q_illegal;
  logic [2:0]  q_wb_sel, q_flags;
  logic [15:0] q_wb_data, q_jmp_addr;

  typedef struct packed {
    logic [15:0] data;
    logic        we;
    logic [2:0]  sel;
    logic [2:0]  flags;
    logic        jmp;
    logic [15:0] addr;
    logic        ill;
    logic [7:0]  busy;
  } res_t;

  int tests = 0;
  int fails = 0;
  logic [2:0] mflags = '0;  // {C,N,Z} as the model believes them

  always #5 i_clk = ~i_clk;

  prco_exec dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp), .i_p_valid(i_p_valid),
    .q_p_stalled(q_p_stalled), .i_p_stalled(i_p_stalled), .q_p_valid(q_p_valid),
    .i_op(i_op), .i_opa(i_opa), .i_opb(i_opb), .i_imm(i_imm), .i_seld(i_seld),
    .q_wb_we(q_wb_we), .q_wb_sel(q_wb_sel), .q_wb_data(q_wb_data), .q_flags(q_flags),
    .q_jmp_en(q_jmp_en), .q_jmp_addr(q_jmp_addr), .q_illegal(q_illegal)
  );

  function automatic logic is_jump(input logic [5:0] op);
    return (op >= 6'h0C) && (op <= 6'h0F);
  endfunction

  task automatic model_exec(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] imm, input logic [2:0] sel, output res_t e);
    int unsigned s;
    logic [15:0] d;
    e = '0;
    e.sel = sel;
    case (op)
      6'h00: ;
      6'h01: begin e.data = imm; e.we = 1; end
      6'h02: begin e.data = b; e.we = 1; end
      6'h03: begin
        s = 32'(a) + 32'(b);
        e.data = 16'(s); e.we = 1;
        mflags = {s > 32'hFFFF, e.data[15], e.data == 16'h0};
      end
      6'h04, 6'h0B: begin
        d = a - b;
        mflags = {a < b, d[15], d == 16'h0};
        if (op == 6'h04) begin e.data = d; e.we = 1; end
      end
      6'h05: begin e.data = a & b; e.we = 1; end
      6'h06: begin e.data = a | b; e.we = 1; end
      6'h07: begin e.data = a ^ b; e.we = 1; end
      6'h08: begin e.data = a << b[3:0]; e.we = 1; e.busy = (b[3:0] == 0) ? 8'd1 : 8'(b[3:0]); end
      6'h09: begin e.data = a >> b[3:0]; e.we = 1; e.busy = (b[3:0] == 0) ? 8'd1 : 8'(b[3:0]); end
      6'h0A: begin e.data = 16'(32'(a) * 32'(b)); e.we = 1; e.busy = 8'd16; end
      6'h0C: e.jmp = 1;
      6'h0D: e.jmp = mflags[0];
      6'h0E: e.jmp = !mflags[0];
      6'h0F: e.jmp = mflags[1];
      default: e.ill = 1;
    endcase
    if (is_jump(op)) e.addr = imm;
    e.flags = mflags;
  endtask

  // Issues one op, waits for its result, returns the observed outputs (busy = stalled cycles before valid)
  task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic [2:0] sel, output res_t r);
    int guard;
    i_op = op; i_opa = a; i_opb = b; i_imm = imm; i_seld = sel; i_p_valid = 1'b1;
    guard = 0;
    while (q_p_stalled && guard < 200) begin @(posedge i_clk); #1; guard++; end
    @(posedge i_clk); #1;
    i_p_valid = 1'b0;
    r = '0;
    guard = 0;
    while (!q_p_valid && guard < 200) begin
      if (q_p_stalled) r.busy = r.busy + 8'd1;
      @(posedge i_clk); #1;
      guard++;
    end
    r.data = q_wb_we ? q_wb_data : 16'h0;
    r.we = q_wb_we; r.sel = q_wb_sel; r.flags = q_flags;
    r.jmp = q_jmp_en; r.addr = is_jump(op) ? q_jmp_addr : 16'h0; r.ill = q_illegal;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    mflags = '0;
    tests++;
    if ({q_p_valid, q_p_stalled, q_wb_we, q_wb_sel, q_wb_data, q_flags, q_jmp_en, q_jmp_addr, q_illegal} !== '0) begin
      fails++;
      $display("FAIL reset: got v=%b st=%b we=%b data=%h flags=%b jmp=%b ill=%b, want all 0",
               q_p_valid, q_p_stalled, q_wb_we, q_wb_data, q_flags, q_jmp_en, q_illegal);
    end
  endtask

  task automatic test_add();
    res_t e, r;
    model_exec(6'h03, 16'hFFFF, 16'h0001, 16'h0, 3'd2, e);
    run_op(6'h03, 16'hFFFF, 16'h0001, 16'h0, 3'd2, r);
    tests++;
    if (r !== e) begin fails++; $display("FAIL add_wrap: got %h want %h", r, e); end
    tests++;
    if ({r.data, r.we, r.flags} !== {16'h0000, 1'b1, 3'b101}) begin
      fails++; $display("FAIL add_flags: got data=%h we=%b flags=%b want 0000 1 101", r.data, r.we, r.flags);
    end
  endtask

  task automatic test_mul();
    res_t e, r;
    model_exec(6'h0A, 16'h0123, 16'h0010, 16'h0, 3'd5, e);
    run_op(6'h0A, 16'h0123, 16'h0010, 16'h0, 3'd5, r);
    tests++;
    if (r !== e || r.data !== 16'h1230 || r.busy !== 8'd16) begin
      fails++; $display("FAIL mul: got %h want %h", r, e);
    end
    @(posedge i_clk); #1;
    tests++;
    if (q_p_valid !== 1'b0) begin fails++; $display("FAIL mul_valid_pulse: got %b want 0", q_p_valid); end
  endtask

  task automatic test_shl_stall();
    res_t e, r, ea;
    model_exec(6'h08, 16'h0001, 16'h0004, 16'h0, 3'd1, e);
    run_op(6'h08, 16'h0001, 16'h0004, 16'h0, 3'd1, r);
    tests++;
    if (r !== e) begin fails++; $display("FAIL shl: got %h want %h", r, e); end
    i_p_stalled = 1'b1;
    i_op = 6'h03; i_opa = 16'h1234; i_opb = 16'h0F0F; i_seld = 3'd6; i_p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      tests++;
      if ({q_p_valid, q_p_stalled, q_wb_data, q_wb_sel} !== {1'b1, 1'b1, 16'h0010, 3'd1}) begin
        fails++; $display("FAIL shl_hold%0d: got v=%b st=%b data=%h sel=%0d want 1 1 0010 1",
                          i, q_p_valid, q_p_stalled, q_wb_data, q_wb_sel);
      end
    end
    i_p_stalled = 1'b0;
    model_exec(6'h03, 16'h1234, 16'h0F0F, 16'h0, 3'd6, ea);
    @(posedge i_clk); #1;
    i_p_valid = 1'b0;
    tests++;
    if ({q_p_valid, q_wb_data, q_wb_sel, q_flags} !== {1'b1, ea.data, ea.sel, ea.flags}) begin
      fails++; $display("FAIL back_to_back: got v=%b data=%h flags=%b want 1 %h %b",
                        q_p_valid, q_wb_data, q_flags, ea.data, ea.flags);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [5] = '{6'h0B, 6'h0D, 6'h0B, 6'h0D, 6'h0F};
    logic [15:0] bs  [5] = '{16'd5, 16'd0, 16'd6, 16'd0, 16'd0};
    logic        tk  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    res_t e, r;
    for (int i = 0; i < 5; i++) begin
      model_exec(ops[i], 16'd5, bs[i], 16'h0040, 3'd0, e);
      run_op(ops[i], 16'd5, bs[i], 16'h0040, 3'd0, r);
      tests++;
      if (r !== e || r.jmp !== tk[i]) begin fails++; $display("FAIL branch%0d: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_flush();
    res_t e, r;
    int seen;
    i_op = 6'h0A; i_opa = 16'h0007; i_opb = 16'h0009; i_seld = 3'd3; i_p_valid = 1'b1;
    @(posedge i_clk); #1;
    i_p_valid = 1'b0;
    repeat (6) begin @(posedge i_clk); #1; end
    i_p_cp = 1'b1;
    @(posedge i_clk); #1;
    i_p_cp = 1'b0;
    tests++;
    if ({q_p_valid, q_p_stalled, q_flags} !== {1'b0, 1'b0, mflags}) begin
      fails++; $display("FAIL flush: got v=%b st=%b flags=%b want 0 0 %b", q_p_valid, q_p_stalled, q_flags, mflags);
    end
    seen = 0;
    repeat (20) begin @(posedge i_clk); #1; if (q_p_valid) seen++; end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL flush_ghost: got %0d valid cycles want 0", seen); end
    model_exec(6'h03, 16'h00F0, 16'h0010, 16'h0, 3'd4, e);
    run_op(6'h03, 16'h00F0, 16'h0010, 16'h0, 3'd4, r);
    tests++;
    if (r !== e) begin fails++; $display("FAIL flush_next_add: got %h want %h", r, e); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'h3F, 6'h10};
    res_t e, r;
    for (int i = 0; i < 2; i++) begin
      model_exec(ops[i], 16'h1111, 16'h2222, 16'h0, 3'd7, e);
      run_op(ops[i], 16'h1111, 16'h2222, 16'h0, 3'd7, r);
      tests++;
      if (r !== e || r.ill !== 1'b1) begin fails++; $display("FAIL illegal%0d: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_reset_mid();
    res_t e, r;
    model_exec(6'h03, 16'hFFFF, 16'h0001, 16'h0, 3'd1, e);
    run_op(6'h03, 16'hFFFF, 16'h0001, 16'h0, 3'd1, r);
    i_op = 6'h09; i_opa = 16'h8000; i_opb = 16'h0008; i_seld = 3'd2; i_p_valid = 1'b1;
    @(posedge i_clk); #1;
    i_p_valid = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    mflags = '0;
    tests++;
    if ({q_p_valid, q_p_stalled, q_wb_we, q_wb_sel, q_wb_data, q_flags, q_jmp_en, q_jmp_addr, q_illegal} !== '0) begin
      fails++; $display("FAIL reset_mid: got v=%b st=%b we=%b data=%h flags=%b want all 0",
                        q_p_valid, q_p_stalled, q_wb_we, q_wb_data, q_flags);
    end
    model_exec(6'h01, 16'h0, 16'h0, 16'hBEEF, 3'd3, e);
    run_op(6'h01, 16'h0, 16'h0, 16'hBEEF, 3'd3, r);
    tests++;
    if (r !== e) begin fails++; $display("FAIL reset_mid_movi: got %h want %h", r, e); end
  endtask

  task automatic test_random();
    res_t e, r;
    logic [5:0] op;
    logic [15:0] a, b, imm;
    logic [2:0] sel;
    for (int i = 0; i < 60; i++) begin
      op  = 6'($urandom_range(0, 16));
      if (op == 6'h10) op = 6'($urandom_range(16, 63));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      imm = 16'($urandom);
      sel = 3'($urandom);
      model_exec(op, a, b, imm, sel, e);
      run_op(op, a, b, imm, sel, r);
      tests++;
      if (r !== e) begin fails++; $display("FAIL random%0d op=%h: got %h want %h", i, op, r, e); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_shl_stall();
    test_branch();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
